dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the far side of the MEM-stage load/store port. It accepts one word-addressed load or store request per handshake and holds it for a programmable number of wait states. It performs the access on a byte-enabled word array and returns a single-cycle response carrying read data and an error flag. While a request is outstanding it raises `busy`, which the hazard unit uses to stall the pipeline in place of a zero-latency memory.

## Interface
Parameters:
- `DEPTH_WORDS`, default 64: number of 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, default 2: wait states between accept and response, 0–15.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  responder can accept this cycle.
- `req_we`  input  1  1 = store, 0 = load.
- `req_addr`  input  32  byte address.
- `req_wdata`  input  32  store data.
- `req_be`  input  4  store byte enables; bit i selects byte lane i.
- `rsp_valid`  output  1  response valid, one-cycle pulse.
- `rsp_rdata`  output  32  load data; 0 for stores and on error.
- `rsp_err`  output  1  access fault, valid with `rsp_valid`.
- `busy`  output  1  request accepted and response not yet delivered.

## Operation
- States: IDLE, WAIT, RESP.
- **Accept.** `req_ready` = 1 in IDLE and RESP, 0 in WAIT. A request is accepted on an edge where `req_valid && req_ready`. On accept, `we`, `addr`, `wdata` and `be` are latched and the wait counter is loaded with `WAIT_CYCLES`.
- **IDLE.** On accept, go to WAIT if `WAIT_CYCLES` > 0, otherwise go directly to RESP.
- **WAIT.** Decrement the counter each cycle. When the counter reaches 1, the next state is RESP.
- **Access.** Performed on the edge that enters RESP.
  - Store: write each byte lane whose `be` bit is set.
  - Load: capture the full word into `rsp_rdata`; `be` is ignored.
  - The word index is `addr[$clog2(DEPTH_WORDS)+1:2]`.
- **Fault.** `rsp_err` = 1 when `addr[1:0]` ≠ 0, or when any bit of `addr[31:$clog2(DEPTH_WORDS)+2]` is set.
  - On fault: no write occurs and `rsp_rdata` = 0.
- **RESP.** `rsp_valid` = 1 for exactly this cycle.
  - If a new request is accepted in this cycle, the next state is WAIT or RESP as from IDLE.
  - Otherwise the next state is IDLE.
- **Response flow control.** None. The consumer must take the response in the RESP cycle.
- **`busy`.** Equals (state == WAIT) or (state == IDLE && `req_valid`). It is combinational, so a stall is raised in the same cycle the request appears.
- **Stores with `be` = 0.** Legal. No bytes change, `rsp_valid` still pulses, and `rsp_err` follows the address checks.

## Timing
- **Reset.** When `reset` is low, asynchronously:
  - state = IDLE, counter = 0.
  - `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0.
  - `req_ready` = 1, and `busy` follows `req_valid`.
  - Array contents are not reset.
  - An in-flight request is dropped; its store is not performed if reset asserts before the RESP edge.
- **Latency.** A request accepted at edge E has `rsp_valid` high in the cycle after edge E + `WAIT_CYCLES`. With `WAIT_CYCLES` = 0 the response appears in the cycle immediately after accept.
- **Throughput.** Back-to-back accept in RESP gives one request per `WAIT_CYCLES`+1 cycles.
- **Read-after-write.** A load accepted in a store's RESP cycle observes the stored data.
- **Request stability.** Request inputs are sampled only at the accept edge; changes while in WAIT are ignored.

## Structure
- Package `dmem_pkg`:
  - `dmem_state_t` enum {IDLE, WAIT, RESP}.
  - `WORD_BYTES` = 4.
  - Request struct type `dmem_req_t` (`we`, `addr`, `wdata`, `be`).
- Sub-module `dmem_array`: `DEPTH_WORDS`×32 storage with synchronous byte-enabled write and asynchronous read, no reset.
- The FSM, counter, fault check and response registers live in `dmem_responder`.

## Test plan
- Reset, then `WAIT_CYCLES`=2, store `addr`=0x10, `wdata`=0xDEADBEEF, `be`=0xF → `rsp_valid` in the 3rd cycle after accept, `rsp_err`=0. A following load of 0x10 → `rsp_rdata`=0xDEADBEEF.
- Store `addr`=0x20, `wdata`=0x11223344, `be`=0xF; then store 0xAABBCCDD with `be`=0x5; then load 0x20 → 0x11BB33DD.
- Load `addr`=0x102 (misaligned) and load `addr`=0x100 (out of range for 64 words) → `rsp_err`=1 and `rsp_rdata`=0 for each. A store to 0x100 leaves word 0 unchanged.
- `WAIT_CYCLES`=0, `req_valid` held high with 4 stores then 4 loads to consecutive words → one response per 1 cycle, `busy` never blocks beyond 1 cycle, loads return the stored data.
- Drive `reset` low during WAIT of a store to 0x30 (prior value 0x0) → no `rsp_valid`, state IDLE, `req_ready`=1; a subsequent load of 0x30 returns 0x0.
- Keep `req_valid` high in WAIT while changing `req_addr` → `req_ready`=0, `busy`=1, and the response uses the address latched at accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states and the latched request record.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic                  we;
        logic [31:0]           addr;
        logic [31:0]           wdata;
        logic [WORD_BYTES-1:0] be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [WORD_BYTES-1:0] req_be;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_array.sv
// Word array with synchronous byte-enabled write and asynchronous read; contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 64,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [WORD_BYTES-1:0] i_be,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one request, waits WAIT_CYCLES, performs the access
// and returns a one-cycle response.
//   state | meaning
//   IDLE  | no request outstanding, ready to accept
//   WAIT  | request latched, counting down wait states
//   RESP  | access done, response valid this cycle, may accept the next request
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    dmem_state_t r_state;
    dmem_state_t w_next;
    logic [3:0]  r_cnt;
    dmem_req_t   r_req;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    dmem_req_t   w_in_req;
    dmem_req_t   w_acc;
    logic        w_ready;
    logic        w_accept;
    logic        w_fault;
    logic        w_enter_resp;
    logic        w_mem_we;
    logic [31:0] w_rdata;

    assign w_in_req = '{we:    bus.req_we,
                        addr:  bus.req_addr,
                        wdata: bus.req_wdata,
                        be:    bus.req_be};

    assign w_ready  = (r_state != WAIT);
    assign w_accept = bus.req_valid && w_ready;

    // Zero-wait requests are performed on their accept edge, before they are latched.
    assign w_acc        = (r_state == WAIT) ? r_req : w_in_req;
    assign w_fault      = (|w_acc.addr[1:0]) || (|w_acc.addr[31:AW+2]);
    assign w_enter_resp = (w_next == RESP);
    assign w_mem_we     = w_enter_resp && w_acc.we && !w_fault;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = RESP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_req <= w_in_req;
                r_cnt <= WAIT_LD;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_rsp_err   <= w_fault;
                r_rsp_rdata <= (w_acc.we || w_fault) ? 32'd0 : w_rdata;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_acc.addr[AW+1:2]),
        .i_wdata (w_acc.wdata),
        .i_be    (w_acc.be),
        .o_rdata (w_rdata)
    );

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = (r_state == WAIT) || ((r_state == IDLE) && bus.req_valid);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven from a vector table and a
// WAIT_CYCLES=0 instance driven back-to-back; responses are checked against a queue.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if bus2();
    dmem_responder_if bus0();

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );
    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    exp_t q2[$];
    exp_t q0[$];
    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e2;
        exp_t e0;
        if (bus2.rsp_valid === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2_unexpected_rsp: rsp_valid=1 at cycle %0d expected no response", cyc);
            end else begin
                e2 = q2.pop_front();
                chk("dut2_rdata",   bus2.rsp_rdata, e2.rdata);
                chk("dut2_err",     32'(bus2.rsp_err), 32'(e2.err));
                chk("dut2_latency", 32'(cyc), 32'(e2.cyc));
            end
        end
        if (bus0.rsp_valid === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_rsp: rsp_valid=1 at cycle %0d expected no response", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("dut0_rdata",   bus0.rsp_rdata, e0.rdata);
                chk("dut0_err",     32'(bus0.rsp_err), 32'(e0.err));
                chk("dut0_latency", 32'(cyc), 32'(e0.cyc));
            end
        end
    end

    task automatic issue2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_we    = we;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        bus2.req_be    = be;
        #1;
        chk("dut2_ready_idle", 32'(bus2.req_ready), 32'd1);
        chk("dut2_busy_idle_valid", 32'(bus2.busy), 32'd1);
        q2.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + 3});
        @(negedge clk);
        bus2.req_valid = 1'b0;
    endtask

    task automatic drain2();
        for (int i = 0; i < 40 && q2.size() != 0; i++) @(negedge clk);
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL dut2_timeout: %0d responses outstanding, expected 0", q2.size());
            q2.delete();
        end
        #1;
        chk("dut2_ready_after", 32'(bus2.req_ready), 32'd1);
        chk("dut2_busy_after",  32'(bus2.busy), 32'd0);
    endtask

    task automatic drain0();
        for (int i = 0; i < 40 && q0.size() != 0; i++) @(negedge clk);
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL dut0_timeout: %0d responses outstanding, expected 0", q0.size());
            q0.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        vt[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
        vt[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0};
        vt[5]  = '{1'b0, 32'h0000_0102, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        vt[6]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        vt[7]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
        vt[8]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
        vt[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h0102_0304, 1'b0};
        vt[10] = '{1'b1, 32'h0000_0024, 32'h5566_7788, 4'hF, 32'h0000_0000, 1'b0};
        vt[11] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        vt[12] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'hF, 32'h5566_7788, 1'b0};
        vt[13] = '{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
        vt[14] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vt[15] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vt[16] = '{1'b1, 32'h0000_0034, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
        vt[17] = '{1'b1, 32'h0000_0038, 32'h9ABC_DEF0, 4'hF, 32'h0000_0000, 1'b0};

        reset = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0; bus2.req_be = '0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.req_be = '0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus2.rsp_err), 32'd0);
        chk("rst_rsp_rdata", bus2.rsp_rdata, 32'd0);
        chk("rst_req_ready", 32'(bus2.req_ready), 32'd1);
        chk("rst_busy",      32'(bus2.busy), 32'd0);
        chk("rst0_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("rst0_req_ready", 32'(bus0.req_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            issue2(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].exp_rd, vt[i].exp_err);
            drain2();
        end

        // Request inputs change during WAIT; the response must use the accept-time address.
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = 32'h34; bus2.req_be = 4'hF;
        q2.push_back('{rdata: 32'h1234_5678, err: 1'b0, cyc: cyc + 3});
        @(negedge clk);
        bus2.req_addr = 32'h38;
        #1;
        chk("wait1_ready", 32'(bus2.req_ready), 32'd0);
        chk("wait1_busy",  32'(bus2.busy), 32'd1);
        @(negedge clk);
        bus2.req_addr = 32'h102;
        #1;
        chk("wait2_ready", 32'(bus2.req_ready), 32'd0);
        chk("wait2_busy",  32'(bus2.busy), 32'd1);
        bus2.req_valid = 1'b0;
        drain2();

        // Zero-wait instance, req_valid held high: 4 stores then 4 loads.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus0.req_valid = 1'b1;
            bus0.req_we    = (i < 4);
            bus0.req_addr  = 32'h40 + 32'(4 * (i % 4));
            bus0.req_wdata = 32'hC0DE_0000 + 32'(i % 4);
            bus0.req_be    = 4'hF;
            #1;
            chk("b2b_ready", 32'(bus0.req_ready), 32'd1);
            chk("b2b_busy",  32'(bus0.busy), (i == 0) ? 32'd1 : 32'd0);
            q0.push_back('{rdata: (i < 4) ? 32'd0 : 32'hC0DE_0000 + 32'(i % 4), err: 1'b0, cyc: cyc + 1});
            @(negedge clk);
        end
        bus0.req_valid = 1'b0;
        drain0();

        // Reset during WAIT of a store drops it.
        issue2(1'b1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0);
        drain2();
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h30;
        bus2.req_wdata = 32'hCAFE_F00D; bus2.req_be = 4'hF;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        chk("midrst_ready",     32'(bus2.req_ready), 32'd1);
        chk("midrst_busy_low",  32'(bus2.busy), 32'd0);
        bus2.req_valid = 1'b1;
        #1;
        chk("midrst_busy_follow", 32'(bus2.busy), 32'd1);
        bus2.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("postrst_ready", 32'(bus2.req_ready), 32'd1);
        issue2(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
        drain2();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
